// File: rtl/spi_adc_poller_pkg.sv
// Shared definitions for the SPI ADC poller.
// Holds the FSM state type, the SPI core register map and the ADC sample width.
package spi_adc_poller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TRDY,
    WRITE,
    WAIT_RRDY,
    READ,
    CAPTURE,
    NEXT
  } state_e;

  // SPI core register addresses
  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int unsigned SAMPLE_W = 12;

endpackage

// File: rtl/spi_adc_poller_if.sv
// Register-bus connection between the poller (master) and the SPI core (slave).
//   spi_select/spi_addr/spi_read_n/spi_write_n/spi_wdata : poller -> core
//   spi_rdata (data_to_cpu), spi_readyfordata (TRDY),
//   spi_dataavailable (RRDY)                               : core -> poller
interface spi_adc_poller_if;
  logic        spi_select;
  logic [2:0]  spi_addr;
  logic        spi_read_n;
  logic        spi_write_n;
  logic [15:0] spi_wdata;
  logic [15:0] spi_rdata;
  logic        spi_readyfordata;
  logic        spi_dataavailable;

  modport master (
    output spi_select, spi_addr, spi_read_n, spi_write_n, spi_wdata,
    input  spi_rdata, spi_readyfordata, spi_dataavailable
  );

  modport slave (
    input  spi_select, spi_addr, spi_read_n, spi_write_n, spi_wdata,
    output spi_rdata, spi_readyfordata, spi_dataavailable
  );
endinterface

// File: rtl/spi_adc_poller_tick_gen.sv
// Poll-rate divider: free-running counter 0..DIV-1.
//   clk, reset : clock, asynchronous active-high reset
//   tick       : high while the counter sits at DIV-1 (one cycle per period)
module poll_tick_gen #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/spi_adc_poller.sv
// Periodically polls NUM_CH ADC channels through an SPI core register interface.
// Each round writes a per-channel command word, waits for RRDY (with timeout),
// reads the result and stores its low 12 bits in that channel's sample slot.
//   clk, reset          : clock, asynchronous active-high reset
//   enable              : polling runs while high
//   spi                 : SPI core register bus (master side)
//   sample_data         : latest sample per channel, channel n at [12n+11:12n]
//   sample_valid/_ch    : one-cycle update pulse and the channel updated
//   busy                : FSM not idle
//   err_timeout/overrun : sticky error flags, cleared only by reset
module spi_adc_poller
  import spi_adc_poller_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned POLL_DIV    = 50000,
  parameter int unsigned TIMEOUT_CYC = 16384,
  parameter logic [15:0] CMD_BASE    = 16'h8310
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  spi_adc_poller_if.master           spi,
  output logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  output logic                       sample_valid,
  output logic [2:0]                 sample_ch,
  output logic                       busy,
  output logic                       err_timeout,
  output logic                       err_overrun
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e        state_q, state_d;
  logic [2:0]    ch_q, ch_d;
  logic          phase_q, phase_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          tick, timeout_hit, capture;

  logic          sel_q, sel_d;
  logic [2:0]    addr_q, addr_d;
  logic          read_n_q, read_n_d;
  logic          write_n_q, write_n_d;
  logic [15:0]   wdata_q, wdata_d;

  logic [NUM_CH*SAMPLE_W-1:0] sample_q;
  logic          valid_q, busy_q, err_to_q, err_ov_q;
  logic [2:0]    sample_ch_q;

  poll_tick_gen #(.DIV(POLL_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    phase_d     = 1'b0;
    to_cnt_d    = '0;
    timeout_hit = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && enable) begin
          state_d = WAIT_TRDY;
          ch_d    = '0;
        end
      end
      WAIT_TRDY: if (spi.spi_readyfordata) state_d = WRITE;
      // phase_q marks the second cycle of a two-cycle bus access
      WRITE: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = WAIT_RRDY;
      end
      WAIT_RRDY: begin
        if (spi.spi_dataavailable) begin
          state_d = READ;
        end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d     = NEXT;
          timeout_hit = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      READ: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        if (ch_q == 3'(NUM_CH - 1) || !enable) begin
          state_d = IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = WAIT_TRDY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes are decoded from the next state so the registered outputs
  // are valid in exactly the cycles the FSM occupies WRITE/READ.
  always_comb begin
    sel_d     = (state_d == WRITE) || (state_d == READ);
    addr_d    = (state_d == WRITE) ? ADDR_TXDATA : ADDR_RXDATA;
    write_n_d = (state_d != WRITE);
    read_n_d  = (state_d != READ);
    wdata_d   = (state_d == WRITE) ? (CMD_BASE | (16'(ch_d) << 10)) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      phase_q     <= 1'b0;
      to_cnt_q    <= '0;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      read_n_q    <= 1'b1;
      write_n_q   <= 1'b1;
      wdata_q     <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      sample_ch_q <= '0;
      busy_q      <= 1'b0;
      err_to_q    <= 1'b0;
      err_ov_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      phase_q   <= phase_d;
      to_cnt_q  <= to_cnt_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      read_n_q  <= read_n_d;
      write_n_q <= write_n_d;
      wdata_q   <= wdata_d;
      valid_q   <= capture;
      busy_q    <= (state_d != IDLE);
      err_to_q  <= err_to_q | timeout_hit;
      // a tick outside IDLE is dropped and flagged
      err_ov_q  <= err_ov_q | (tick && state_q != IDLE);
      if (capture) sample_ch_q <= ch_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (capture && ch_q == 3'(i))
          sample_q[i*SAMPLE_W +: SAMPLE_W] <= spi.spi_rdata[SAMPLE_W-1:0];
      end
    end
  end

  assign spi.spi_select  = sel_q;
  assign spi.spi_addr    = addr_q;
  assign spi.spi_read_n  = read_n_q;
  assign spi.spi_write_n = write_n_q;
  assign spi.spi_wdata   = wdata_q;
  assign sample_data     = sample_q;
  assign sample_valid    = valid_q;
  assign sample_ch       = sample_ch_q;
  assign busy            = busy_q;
  assign err_timeout     = err_to_q;
  assign err_overrun     = err_ov_q;

endmodule

// File: tb/tb_spi_adc_poller.sv
// Bench for spi_adc_poller. Three instances run side by side:
//   a : normal polling (fixed then random ADC data), enable dropped mid-round
//   b : SPI core never raises RRDY (timeout path), reset pulsed during WRITE
//   c : poll period shorter than a round (overrun path)
module tb_spi_adc_poller;

  localparam int unsigned RRDY_DLY = 6664;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- instances ----------------
  logic        reset_a = 1'b1, enable_a = 1'b0;
  logic        reset_b = 1'b1, enable_b = 1'b0;
  logic        reset_c = 1'b1, enable_c = 1'b0;
  logic [23:0] sample_data_a, sample_data_b, sample_data_c;
  logic        sample_valid_a, sample_valid_b, sample_valid_c;
  logic [2:0]  sample_ch_a, sample_ch_b, sample_ch_c;
  logic        busy_a, busy_b, busy_c;
  logic        err_to_a, err_to_b, err_to_c;
  logic        err_ov_a, err_ov_b, err_ov_c;

  spi_adc_poller_if bus_a ();
  spi_adc_poller_if bus_b ();
  spi_adc_poller_if bus_c ();

  spi_adc_poller #(.NUM_CH(2), .POLL_DIV(20000)) dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .spi(bus_a),
    .sample_data(sample_data_a), .sample_valid(sample_valid_a), .sample_ch(sample_ch_a),
    .busy(busy_a), .err_timeout(err_to_a), .err_overrun(err_ov_a)
  );

  spi_adc_poller #(.NUM_CH(2), .POLL_DIV(20000), .TIMEOUT_CYC(100)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .spi(bus_b),
    .sample_data(sample_data_b), .sample_valid(sample_valid_b), .sample_ch(sample_ch_b),
    .busy(busy_b), .err_timeout(err_to_b), .err_overrun(err_ov_b)
  );

  spi_adc_poller #(.NUM_CH(2), .POLL_DIV(5000)) dut_c (
    .clk(clk), .reset(reset_c), .enable(enable_c), .spi(bus_c),
    .sample_data(sample_data_c), .sample_valid(sample_valid_c), .sample_ch(sample_ch_c),
    .busy(busy_c), .err_timeout(err_to_c), .err_overrun(err_ov_c)
  );

  // ---------------- SPI core models ----------------
  // RRDY rises RRDY_DLY cycles after a write starts and drops when read.
  logic [15:0]  a_rx_q[$];
  int unsigned  a_cnt = 0;
  logic         a_prev_wn = 1'b1;
  int unsigned  c_cnt = 0;
  logic         c_prev_wn = 1'b1;
  logic [15:0]  c_last = '0;

  initial begin
    bus_a.spi_rdata = '0; bus_a.spi_readyfordata = 1'b1; bus_a.spi_dataavailable = 1'b0;
    bus_b.spi_rdata = 16'hFFFF; bus_b.spi_readyfordata = 1'b1; bus_b.spi_dataavailable = 1'b0;
    bus_c.spi_rdata = '0; bus_c.spi_readyfordata = 1'b1; bus_c.spi_dataavailable = 1'b0;
  end

  always @(negedge clk) begin
    if (reset_a) begin
      a_cnt = 0; a_prev_wn = 1'b1; bus_a.spi_dataavailable = 1'b0;
    end else begin
      bus_a.spi_readyfordata = ($urandom_range(3) != 0);
      if (!bus_a.spi_read_n && bus_a.spi_select) bus_a.spi_dataavailable = 1'b0;
      if (a_prev_wn && !bus_a.spi_write_n) a_cnt = RRDY_DLY;
      else if (a_cnt != 0) begin
        a_cnt--;
        if (a_cnt == 0) begin
          bus_a.spi_dataavailable = 1'b1;
          bus_a.spi_rdata = (a_rx_q.size() != 0) ? a_rx_q.pop_front() : 16'hDEAD;
        end
      end
      a_prev_wn = bus_a.spi_write_n;
    end
  end

  always @(negedge clk) begin
    if (reset_c) begin
      c_cnt = 0; c_prev_wn = 1'b1; bus_c.spi_dataavailable = 1'b0;
    end else begin
      bus_c.spi_readyfordata = ($urandom_range(3) != 0);
      if (!bus_c.spi_read_n && bus_c.spi_select) bus_c.spi_dataavailable = 1'b0;
      if (c_prev_wn && !bus_c.spi_write_n) c_cnt = RRDY_DLY;
      else if (c_cnt != 0) begin
        c_cnt--;
        if (c_cnt == 0) begin
          c_last = 16'($urandom);
          bus_c.spi_dataavailable = 1'b1;
          bus_c.spi_rdata = c_last;
        end
      end
      c_prev_wn = bus_c.spi_write_n;
    end
  end

  // ---------------- monitors / scoreboards ----------------
  logic [15:0] a_exp_cmd[$];
  logic [14:0] a_exp_s[$];       // {channel, 12-bit data}
  logic [23:0] a_model = '0;
  int unsigned a_writes = 0, a_valids = 0, a_wlen = 0, a_rlen = 0;

  always @(negedge clk) begin
    if (!reset_a) begin
      if (!bus_a.spi_write_n) begin
        if (a_wlen == 0) begin
          a_writes++;
          if (a_exp_cmd.size() == 0) check("a_unexpected_write", 32'(bus_a.spi_wdata), 32'h0);
          else check("a_wdata", 32'(bus_a.spi_wdata), 32'(a_exp_cmd.pop_front()));
          check("a_write_sel_addr", 32'({bus_a.spi_select, bus_a.spi_addr}), 32'h9);
        end
        a_wlen++;
      end else if (a_wlen != 0) begin
        check("a_write_len", a_wlen, 2);
        a_wlen = 0;
      end
      if (!bus_a.spi_read_n) begin
        if (a_rlen == 0) check("a_read_sel_addr", 32'({bus_a.spi_select, bus_a.spi_addr}), 32'h8);
        a_rlen++;
      end else if (a_rlen != 0) begin
        check("a_read_len", a_rlen, 2);
        a_rlen = 0;
      end
      if (sample_valid_a) begin
        a_valids++;
        if (a_exp_s.size() == 0) check("a_unexpected_valid", 32'(sample_valid_a), 32'h0);
        else begin
          logic [14:0] e;
          e = a_exp_s.pop_front();
          a_model[int'(e[14:12])*12 +: 12] = e[11:0];
          check("a_sample_ch", 32'(sample_ch_a), 32'(e[14:12]));
          check("a_sample_data", 32'(sample_data_a), 32'(a_model));
        end
      end
    end
  end

  int unsigned b_writes = 0, b_valids = 0;
  logic        b_prev_wn = 1'b1;

  always @(negedge clk) begin
    if (reset_b) b_prev_wn = 1'b1;
    else begin
      if (sample_valid_b) b_valids++;
      if (b_prev_wn && !bus_b.spi_write_n) b_writes++;
      b_prev_wn = bus_b.spi_write_n;
    end
  end

  int unsigned c_writes = 0, c_caps = 0, c_wlen = 0, c_rlen = 0;

  always @(negedge clk) begin
    if (!reset_c) begin
      if (!bus_c.spi_write_n) begin
        if (c_wlen == 0) begin
          logic [15:0] cmd;
          cmd = 16'h8310 | (16'(c_writes % 2) << 10);
          check("c_wdata", 32'(bus_c.spi_wdata), 32'(cmd));
          c_writes++;
        end
        c_wlen++;
      end else if (c_wlen != 0) begin
        check("c_write_len", c_wlen, 2);
        c_wlen = 0;
      end
      if (!bus_c.spi_read_n) c_rlen++;
      else if (c_rlen != 0) begin
        check("c_read_len", c_rlen, 2);
        c_rlen = 0;
      end
      if (sample_valid_c) begin
        int unsigned ech;
        ech = c_caps % 2;
        check("c_sample_ch", 32'(sample_ch_c), ech);
        check("c_sample_data", 32'(sample_data_c[ech*12 +: 12]), 32'(c_last[11:0]));
        c_caps++;
      end
    end
  end

  // ---------------- sequences ----------------
  initial begin
    fork
      begin : seq_a
        int n;
        logic [15:0] r0;
        repeat (3) @(negedge clk);
        check("a_rst_data", 32'(sample_data_a), 32'h0);
        check("a_rst_flags", 32'({sample_valid_a, sample_ch_a, busy_a, err_to_a, err_ov_a}), 32'h0);
        check("a_rst_bus", 32'({bus_a.spi_select, bus_a.spi_addr, bus_a.spi_read_n,
                                bus_a.spi_write_n, bus_a.spi_wdata}), 32'h30000);
        a_rx_q.push_back(16'h0ABC); a_rx_q.push_back(16'h0123);
        a_exp_cmd.push_back(16'h8310); a_exp_cmd.push_back(16'h8710);
        a_exp_s.push_back({3'd0, 12'hABC}); a_exp_s.push_back({3'd1, 12'h123});
        reset_a = 1'b0; enable_a = 1'b1;
        n = 0; while (!busy_a && n < 25000) begin @(negedge clk); n++; end
        check("a_r1_start", 32'(busy_a), 32'h1);
        n = 0; while (busy_a && n < 20000) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check("a_r1_data", 32'(sample_data_a), 32'h123ABC);
        check("a_r1_pulses", a_valids, 2);
        check("a_r1_errs", 32'({err_to_a, err_ov_a}), 32'h0);
        check("a_r1_cmds_left", a_exp_cmd.size(), 0);
        // round 2: enable dropped while channel 0 waits for RRDY
        r0 = 16'($urandom);
        a_rx_q.push_back(r0);
        a_exp_cmd.push_back(16'h8310);
        a_exp_s.push_back({3'd0, r0[11:0]});
        n = 0; while (!busy_a && n < 25000) begin @(negedge clk); n++; end
        repeat (200) @(negedge clk);
        check("a_r2_waiting", 32'({busy_a, 4'(a_writes)}), 32'h13);
        enable_a = 1'b0;
        n = 0; while (busy_a && n < 20000) begin @(negedge clk); n++; end
        repeat (100) @(negedge clk);
        check("a_r2_data", 32'(sample_data_a), 32'({12'h123, r0[11:0]}));
        check("a_r2_writes", a_writes, 3);
        check("a_r2_pulses", a_valids, 3);
        check("a_r2_busy", 32'(busy_a), 32'h0);
      end
      begin : seq_b
        int n;
        repeat (3) @(negedge clk);
        check("b_rst_flags", 32'({busy_b, err_to_b, err_ov_b}), 32'h0);
        reset_b = 1'b0; enable_b = 1'b1;
        n = 0; while (bus_b.spi_write_n && n < 25000) begin @(negedge clk); n++; end
        check("b_wdata0", 32'(bus_b.spi_wdata), 32'h8310);
        n = 0; while (!bus_b.spi_write_n && n < 5) begin @(negedge clk); n++; end
        n = 0; while (!err_to_b && n < 300) begin @(negedge clk); n++; end
        check("b_timeout_cycles", n, 100);
        check("b_busy_after_to", 32'(busy_b), 32'h1);
        n = 0; while (busy_b && n < 1000) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check("b_round_done", 32'({busy_b, err_to_b}), 32'h1);
        check("b_data_kept", 32'(sample_data_b), 32'h0);
        check("b_no_valid", b_valids, 0);
        check("b_writes", b_writes, 2);
        // reset pulsed in the first cycle of a WRITE
        n = 0; while (bus_b.spi_write_n && n < 25000) begin @(negedge clk); n++; end
        check("b_in_write", 32'({bus_b.spi_select, bus_b.spi_write_n}), 32'h2);
        reset_b = 1'b1;
        #1;
        check("b_rst_bus", 32'({bus_b.spi_select, bus_b.spi_write_n, bus_b.spi_read_n, bus_b.spi_wdata}),
              32'h30000);
        check("b_rst_outs", 32'({sample_data_b, sample_valid_b, sample_ch_b, busy_b, err_to_b, err_ov_b}),
              32'h0);
        repeat (2) @(negedge clk);
        reset_b = 1'b0;
        n = 0; while (bus_b.spi_write_n && n < 25000) begin @(negedge clk); n++; end
        check("b_restart_gap", n, 20001);
        check("b_restart_ch0", 32'(bus_b.spi_wdata), 32'h8310);
      end
      begin : seq_c
        repeat (3) @(negedge clk);
        reset_c = 1'b0; enable_c = 1'b1;
        repeat (9000) @(negedge clk);
        check("c_pre_overrun", 32'({busy_c, err_ov_c}), 32'h2);
        repeat (2000) @(negedge clk);
        check("c_overrun", 32'(err_ov_c), 32'h1);
        repeat (30000) @(negedge clk);
        check("c_captures", 32'(c_caps >= 4), 32'h1);
        check("c_no_timeout", 32'(err_to_c), 32'h0);
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/spi_adc_poller.md
SPI_ADC_POLLER -- requirements
Module: spi_adc_poller

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of ADC channels polled per round, 1..8.
REQ-002 SHALL have parameter POLL_DIV, default 50000: clk cycles between round starts (1 kHz at 50 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16384: maximum wait for dataavailable, in clk cycles.
REQ-004 SHALL have parameter CMD_BASE, default 16'h8310: command word for channel 0; the channel index is ORed into bits [12:10].
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Port: clk  in  1  system clock.
REQ-007 Port: reset  in  1  asynchronous active-high reset.
REQ-008 Port: enable  in  1  level; polling runs while high.
REQ-009 Port: spi_select  out  1  SPI core chip-select.
REQ-010 Port: spi_addr  out  3  SPI core register address.
REQ-011 Port: spi_read_n  out  1  SPI core read strobe, active low.
REQ-012 Port: spi_write_n  out  1  SPI core write strobe, active low.
REQ-013 Port: spi_wdata  out  16  data written to the SPI core.
REQ-014 Port: spi_rdata  in  16  SPI core data_to_cpu.
REQ-015 Port: spi_readyfordata  in  1  SPI core TRDY.
REQ-016 Port: spi_dataavailable  in  1  SPI core RRDY.
REQ-017 Port: sample_data  out  NUM_CH*12  latest 12-bit result per channel; channel n occupies bits [12n+11:12n].
REQ-018 Port: sample_valid  out  1  one-cycle pulse when a channel result is updated.
REQ-019 Port: sample_ch  out  3  index of the channel just updated; valid while sample_valid is high.
REQ-020 Port: busy  out  1  high in every state except IDLE.
REQ-021 Port: err_timeout  out  1  sticky; set on a dataavailable timeout.
REQ-022 Port: err_overrun  out  1  sticky; set when a tick occurs while busy.

Function
REQ-023 A tick counter SHALL count 0..POLL_DIV-1 and wrap; tick is asserted at count POLL_DIV-1 and the counter runs regardless of enable.
REQ-024 FSM states SHALL be IDLE, WAIT_TRDY, WRITE, WAIT_RRDY, READ, CAPTURE, NEXT.
REQ-025 IDLE -> WAIT_TRDY on (tick & enable); ch is set to 0.
REQ-026 WAIT_TRDY -> WRITE when spi_readyfordata = 1.
REQ-027 WRITE SHALL last exactly 2 cycles with spi_select=1, spi_addr=1, spi_write_n=0, spi_wdata=CMD_BASE|(ch<<10); it then goes to WAIT_RRDY.
REQ-028 WAIT_RRDY -> READ when spi_dataavailable = 1.
REQ-029 WAIT_RRDY -> NEXT after TIMEOUT_CYC cycles without spi_dataavailable; err_timeout is set and sample_data is left unchanged.
REQ-030 READ SHALL last exactly 2 cycles with spi_select=1, spi_addr=0, spi_read_n=0; spi_rdata is sampled on the cycle after READ ends (CAPTURE).
REQ-031 CAPTURE SHALL write spi_rdata[11:0] into the ch slot of sample_data, pulse sample_valid for 1 cycle with sample_ch=ch, then go to NEXT.
REQ-032 NEXT: if ch = NUM_CH-1 or enable = 0 -> IDLE; otherwise ch increments -> WAIT_TRDY.
REQ-033 Deasserting enable mid-transaction SHALL complete the current channel and never abort a bus access.
REQ-034 A tick while not in IDLE SHALL be dropped and SHALL set err_overrun.
REQ-035 Outside WRITE and READ: spi_select=0, spi_read_n=1, spi_write_n=1, spi_addr=0, spi_wdata=0.
REQ-036 Errors SHALL clear only on reset.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 Reset SHALL put the FSM in IDLE and clear ch, the tick counter, the timeout counter, sample_data, sample_valid, sample_ch, busy and both error flags; bus outputs SHALL take their REQ-035 values.
REQ-039 Reset asserted mid-access SHALL immediately deassert spi_select, spi_read_n and spi_write_n.

Structure
REQ-040 A shared package SHALL hold the FSM state enum, the SPI register address constants (RXDATA=0, TXDATA=1, STATUS=2, CONTROL=3) and the 12-bit sample width.
REQ-041 The tick divider SHALL be a sub-module, poll_tick_gen, with parameter DIV and outputs tick.

Verification
REQ-042 Bench SHALL use an SPI-core behavioural model (RRDY set 6664 cycles after a data write, cleared on read) and shall use NUM_CH=2, POLL_DIV=20000.
REQ-043 enable=1, model returns 16'h0ABC then 16'h0123 -> sample_data = {12'h123, 12'hABC}; two sample_valid pulses with sample_ch 0 then 1; spi_wdata 16'h8310 then 16'h8710.
REQ-044 Model never sets RRDY, TIMEOUT_CYC=100 -> err_timeout=1 after 100 cycles in WAIT_RRDY, sample_data stays 0, round completes and returns to IDLE.
REQ-045 POLL_DIV=5000 (less than a round) -> err_overrun=1 and no access is interrupted.
REQ-046 enable dropped during ch0 WAIT_RRDY -> ch0 captured, no ch1 write, busy=0.
REQ-047 Reset pulsed during WRITE -> spi_write_n=1 and spi_select=0 in the same cycle, all outputs 0, and the next tick starts at ch0.
